// File: rtl/ccr_flag_if.sv
// Condition-code register bus: ALU/control flag updates in, CCR state and branch condition vector out.
// Combinational bundle only; no latency and no backpressure.
interface ccr_flag_if;
    logic       alu_flags_we;
    logic [3:0] alu_flags;
    logic [3:0] alu_flag_mask;
    logic       setc;
    logic       clrc;
    logic       int_save;
    logic       rti_restore;
    logic [3:0] flags;
    logic [7:0] cond_vec;
    logic       shadow_valid;
    logic       nest_err;

    modport master (
        output alu_flags_we, alu_flags, alu_flag_mask, setc, clrc, int_save, rti_restore,
        input  flags, cond_vec, shadow_valid, nest_err
    );

    modport slave (
        input  alu_flags_we, alu_flags, alu_flag_mask, setc, clrc, int_save, rti_restore,
        output flags, cond_vec, shadow_valid, nest_err
    );
endinterface

// File: rtl/ccr_flag_unit.sv
// Condition-code register {V,C,N,Z} with partial ALU update, SETC/CLRC, one-level interrupt shadow.
// Latency: 1 cycle input->flags; cond_vec is 0 cycles (BYPASS=1) or 1 cycle (BYPASS=0).
// Backpressure: none; every input is accepted each cycle, illegal save/restore reported on nest_err.
module ccr_flag_unit #(
    parameter bit         BYPASS      = 1'b0,
    parameter logic [3:0] RESET_FLAGS = 4'b0000
) (
    input  logic      clk,
    input  logic      rst,
    ccr_flag_if.slave ccr
);
    localparam int FZ = 0;
    localparam int FN = 1;
    localparam int FC = 2;
    localparam int FV = 3;

    typedef enum logic {
        SHADOW_EMPTY,
        SHADOW_FULL
    } shadow_state_t;

    shadow_state_t state_q, state_d;
    logic [3:0]    flags_q;
    logic [3:0]    shadow_q;
    logic [3:0]    nxt;
    logic [3:0]    cond_src;
    logic          nest_err_q;
    logic          restore_hit;
    logic          save_hit;
    logic          seq_err;

    // A valid restore overrides every other update source for the cycle.
    always_comb begin
        nxt         = flags_q;
        restore_hit = ccr.rti_restore && (state_q == SHADOW_FULL);
        if (restore_hit) begin
            nxt = shadow_q;
        end else begin
            if (ccr.alu_flags_we) begin
                nxt = (flags_q & ~ccr.alu_flag_mask) | (ccr.alu_flags & ccr.alu_flag_mask);
            end
            if (ccr.setc) begin
                nxt[FC] = 1'b1;
            end
            if (ccr.clrc) begin
                nxt[FC] = 1'b0;
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        save_hit = 1'b0;
        seq_err  = 1'b0;
        case (state_q)
            SHADOW_EMPTY: begin
                // Restore with nothing saved is an error, and it also swallows a same-cycle save.
                if (ccr.rti_restore) begin
                    seq_err = 1'b1;
                end else if (ccr.int_save) begin
                    save_hit = 1'b1;
                    state_d  = SHADOW_FULL;
                end
            end
            SHADOW_FULL: begin
                if (ccr.rti_restore) begin
                    state_d = SHADOW_EMPTY;
                    seq_err = ccr.int_save;
                end else if (ccr.int_save) begin
                    seq_err = 1'b1;
                end
            end
            default: begin
                state_d = SHADOW_EMPTY;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            flags_q    <= RESET_FLAGS;
            shadow_q   <= 4'b0000;
            state_q    <= SHADOW_EMPTY;
            nest_err_q <= 1'b0;
        end else begin
            flags_q    <= nxt;
            state_q    <= state_d;
            nest_err_q <= seq_err;
            if (save_hit) begin
                shadow_q <= nxt;
            end
        end
    end

    assign cond_src = BYPASS ? nxt : flags_q;

    assign ccr.cond_vec[0] = 1'b1;
    assign ccr.cond_vec[1] = cond_src[FZ];
    assign ccr.cond_vec[2] = ~cond_src[FZ];
    assign ccr.cond_vec[3] = cond_src[FC];
    assign ccr.cond_vec[4] = ~cond_src[FC];
    assign ccr.cond_vec[5] = cond_src[FN];
    assign ccr.cond_vec[6] = cond_src[FV];
    assign ccr.cond_vec[7] = cond_src[FN] ^ cond_src[FV];

    assign ccr.flags        = flags_q;
    assign ccr.shadow_valid = (state_q == SHADOW_FULL);
    assign ccr.nest_err     = nest_err_q;
endmodule
